// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared constants for the multicycle MIPS control unit: ALU codes,
// opcodes/functs, operand/PC select encodings, state codes and the
// bundle of datapath controls the FSM registers.
package unidade_controle_multiciclo_pkg;

  localparam logic [3:0] ULA_ADD = 4'b0000;
  localparam logic [3:0] ULA_SUB = 4'b0010;
  localparam logic [3:0] ULA_AND = 4'b0100;
  localparam logic [3:0] ULA_OR  = 4'b0101;
  localparam logic [3:0] ULA_NOR = 4'b0110;
  localparam logic [3:0] ULA_XOR = 4'b0111;
  localparam logic [3:0] ULA_SLT = 4'b1000;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] FB_REG_B    = 3'b000;
  localparam logic [2:0] FB_QUATRO   = 3'b001;
  localparam logic [2:0] FB_IMM      = 3'b010;
  localparam logic [2:0] FB_IMM_DESL = 3'b011;
  localparam logic [2:0] FB_IMM_ZERO = 3'b100;

  localparam logic [1:0] FPC_ULA    = 2'b00;
  localparam logic [1:0] FPC_ULAOUT = 2'b01;
  localparam logic [1:0] FPC_SALTO  = 2'b10;

  typedef enum logic [3:0] {
    INICIO      = 4'd0,
    BUSCA       = 4'd1,
    DECODIFICA  = 4'd2,
    EXEC_R      = 4'd3,
    EXEC_I      = 4'd4,
    ENDERECO    = 4'd5,
    MEM_LE      = 4'd6,
    ESCRITA_MEM = 4'd7,
    ESCRITA_REG = 4'd8,
    DESVIO      = 4'd9,
    SALTO       = 4'd10,
    ERRO        = 4'd11
  } estado_t;

  typedef struct packed {
    logic [3:0] ula_controle;
    logic       ula_fonte_a;
    logic [2:0] ula_fonte_b;
    logic [1:0] fonte_pc;
    logic       escreve_pc;
    logic       escreve_ir;
    logic       le_mem;
    logic       escreve_mem;
    logic       iord;
    logic       escreve_reg;
    logic       reg_dst;
    logic       mem_para_reg;
    logic       erro;
  } saidas_t;

endpackage

// File: rtl/unidade_controle_multiciclo_decodificador_funcao.sv
// R-type funct field to ALU operation code; valido low for unsupported functs
// (ula_codigo is then ADD/0000).
module decodificador_funcao
  import unidade_controle_multiciclo_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] ula_codigo,
  output logic       valido
);

  // Pure lookup of the supported funct values.
  always_comb begin
    ula_codigo = ULA_ADD;
    valido     = 1'b1;
    case (funct)
      FN_ADD:  ula_codigo = ULA_ADD;
      FN_SUB:  ula_codigo = ULA_SUB;
      FN_AND:  ula_codigo = ULA_AND;
      FN_OR:   ula_codigo = ULA_OR;
      FN_XOR:  ula_codigo = ULA_XOR;
      FN_NOR:  ula_codigo = ULA_NOR;
      FN_SLT:  ula_codigo = ULA_SLT;
      default: valido     = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS control unit. Outputs are registered together with the
// state (decoded from the next state), so each is a pure function of the
// state register; the only exception is escreve_pc in DESVIO, which follows
// zero combinationally.
//
// state       | meaning
// INICIO      | reset, everything idle
// BUSCA       | fetch IR, PC <= PC+4
// DECODIFICA  | branch target into ALUOut, dispatch on opcode
// EXEC_R      | R-type ALU operation
// EXEC_I      | immediate ALU operation
// ENDERECO    | lw/sw address computation
// MEM_LE      | data memory read
// ESCRITA_MEM | data memory write
// ESCRITA_REG | register file write-back
// DESVIO      | beq/bne compare and conditional PC update
// SALTO       | jump
// ERRO        | illegal instruction, absorbing until reset
module unidade_controle_multiciclo
  import unidade_controle_multiciclo_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] ula_controle,
  output logic       ula_fonte_a,
  output logic [2:0] ula_fonte_b,
  output logic [1:0] fonte_pc,
  output logic       escreve_pc,
  output logic       escreve_ir,
  output logic       le_mem,
  output logic       escreve_mem,
  output logic       iord,
  output logic       escreve_reg,
  output logic       reg_dst,
  output logic       mem_para_reg,
  output logic       erro,
  output logic [3:0] estado
);

  estado_t atual, prox;
  saidas_t s_q, s_prox;
  logic    eh_beq;
  logic [3:0] funct_ula;
  logic       funct_valido;

  decodificador_funcao u_decodificador_funcao (
    .funct      (funct),
    .ula_codigo (funct_ula),
    .valido     (funct_valido)
  );

  // Next state, then the control word that belongs to that next state.
  always_comb begin
    prox   = atual;
    s_prox = '0;
    case (atual)
      INICIO:     prox = BUSCA;
      BUSCA:      prox = DECODIFICA;
      DECODIFICA: begin
        case (opcode)
          OP_R:                                     prox = EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: prox = EXEC_I;
          OP_LW, OP_SW:                             prox = ENDERECO;
          OP_BEQ, OP_BNE:                           prox = DESVIO;
          OP_J:                                     prox = SALTO;
          default:                                  prox = ERRO;
        endcase
      end
      EXEC_R:      prox = funct_valido ? ESCRITA_REG : ERRO;
      EXEC_I:      prox = ESCRITA_REG;
      ENDERECO:    prox = (opcode == OP_SW) ? ESCRITA_MEM : MEM_LE;
      MEM_LE:      prox = ESCRITA_REG;
      ESCRITA_MEM,
      ESCRITA_REG,
      DESVIO,
      SALTO:       prox = BUSCA;
      ERRO:        prox = ERRO;
      default:     prox = ERRO;
    endcase

    case (prox)
      BUSCA: begin
        s_prox.le_mem      = 1'b1;
        s_prox.escreve_ir  = 1'b1;
        s_prox.escreve_pc  = 1'b1;
        s_prox.ula_fonte_b = FB_QUATRO;
        s_prox.fonte_pc    = FPC_ULA;
      end
      DECODIFICA: s_prox.ula_fonte_b = FB_IMM_DESL;
      EXEC_R: begin
        s_prox.ula_controle = funct_ula;
        s_prox.ula_fonte_a  = 1'b1;
        s_prox.ula_fonte_b  = FB_REG_B;
      end
      EXEC_I: begin
        s_prox.ula_fonte_a = 1'b1;
        case (opcode)
          OP_SLTI: begin s_prox.ula_controle = ULA_SLT; s_prox.ula_fonte_b = FB_IMM;      end
          OP_ANDI: begin s_prox.ula_controle = ULA_AND; s_prox.ula_fonte_b = FB_IMM_ZERO; end
          OP_ORI:  begin s_prox.ula_controle = ULA_OR;  s_prox.ula_fonte_b = FB_IMM_ZERO; end
          OP_XORI: begin s_prox.ula_controle = ULA_XOR; s_prox.ula_fonte_b = FB_IMM_ZERO; end
          default: begin s_prox.ula_controle = ULA_ADD; s_prox.ula_fonte_b = FB_IMM;      end
        endcase
      end
      ENDERECO: begin
        s_prox.ula_fonte_a = 1'b1;
        s_prox.ula_fonte_b = FB_IMM;
      end
      MEM_LE: begin
        s_prox.le_mem = 1'b1;
        s_prox.iord   = 1'b1;
      end
      ESCRITA_MEM: begin
        s_prox.escreve_mem = 1'b1;
        s_prox.iord        = 1'b1;
      end
      ESCRITA_REG: begin
        // The source state tells the instruction class: R-type writes rd,
        // lw writes memory data, I-ALU writes the ALU result to rt.
        s_prox.escreve_reg  = 1'b1;
        s_prox.reg_dst      = (atual == EXEC_R);
        s_prox.mem_para_reg = (atual == MEM_LE);
      end
      DESVIO: begin
        s_prox.ula_controle = ULA_SUB;
        s_prox.ula_fonte_a  = 1'b1;
        s_prox.ula_fonte_b  = FB_REG_B;
        s_prox.fonte_pc     = FPC_ULAOUT;
      end
      SALTO: begin
        s_prox.fonte_pc   = FPC_SALTO;
        s_prox.escreve_pc = 1'b1;
      end
      ERRO:    s_prox.erro = 1'b1;
      default: s_prox = '0;
    endcase
  end

  // State, registered control word and the beq/bne class bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      atual  <= INICIO;
      s_q    <= '0;
      eh_beq <= 1'b0;
    end else begin
      atual  <= prox;
      s_q    <= s_prox;
      eh_beq <= (opcode == OP_BEQ);
    end
  end

  assign ula_controle = s_q.ula_controle;
  assign ula_fonte_a  = s_q.ula_fonte_a;
  assign ula_fonte_b  = s_q.ula_fonte_b;
  assign fonte_pc     = s_q.fonte_pc;
  assign escreve_pc   = s_q.escreve_pc |
                        ((atual == DESVIO) & (eh_beq ? zero : ~zero));
  assign escreve_ir   = s_q.escreve_ir;
  assign le_mem       = s_q.le_mem;
  assign escreve_mem  = s_q.escreve_mem;
  assign iord         = s_q.iord;
  assign escreve_reg  = s_q.escreve_reg;
  assign reg_dst      = s_q.reg_dst;
  assign mem_para_reg = s_q.mem_para_reg;
  assign erro         = s_q.erro;
  assign estado       = atual;

endmodule
